// File: rtl/eaglesong_pkg.sv
// Shared types and constants for the Eaglesong sponge absorb datapath.
// No configuration macros here; see eaglesong_absorb.sv for EAGLESONG_ABSORB_LEN_CHECK_EN.
package eaglesong_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned RATE_WORDS = 8;
    localparam int unsigned RATE_BYTES = 32;
    localparam int unsigned LEN_W      = 7;
    localparam int unsigned ROUND_W    = 8;
    localparam int unsigned GIDX_W     = 13;

    localparam logic [7:0]       DELIMITER = 8'h06;
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(RATE_BYTES);

    typedef logic [WORD_W-1:0] word_t;

    // Global message byte index of byte k inside word j of absorb block `round`.
    function automatic logic [GIDX_W-1:0] byte_gidx(
        input logic [ROUND_W-1:0] round,
        input int unsigned        j,
        input int unsigned        k
    );
        return {round, 5'b0} + GIDX_W'(j * 4 + k);
    endfunction

endpackage

// File: rtl/eaglesong_absorb_pack.sv
// Combinational packer: message bytes plus 0x06 delimiter into big-endian rate words.
// Bytes past the delimiter do not shift, so a partial word ends up right-aligned.
module eaglesong_absorb_pack
    import eaglesong_pkg::*;
(
    input  logic [RATE_BYTES*8-1:0]        i_input_val,
    input  logic [LEN_W-1:0]               i_len,
    input  logic [ROUND_W-1:0]             i_round,
    output word_t [RATE_WORDS-1:0]         o_words
);

    logic [GIDX_W-1:0] w_len_g;

    assign w_len_g = GIDX_W'(i_len);

    always_comb begin
        o_words = '0;
        for (int unsigned j = 0; j < RATE_WORDS; j++) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (byte_gidx(i_round, j, k) < w_len_g) begin
                    o_words[j] = {o_words[j][WORD_W-9:0], i_input_val[8*(4*j+k) +: 8]};
                end else if (byte_gidx(i_round, j, k) == w_len_g) begin
                    o_words[j] = {o_words[j][WORD_W-9:0], DELIMITER};
                end
            end
        end
    end

endmodule

// File: rtl/eaglesong_absorb.sv
// Eaglesong absorb step: XOR packed message words into the rate half, one-cycle registered.
// Define EAGLESONG_ABSORB_LEN_CHECK_EN to reject lengths 0 or >32 via the len_err output.
module eaglesong_absorb
    import eaglesong_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  word_t [RATE_WORDS-1:0]     state_input,
    input  logic [RATE_BYTES*8-1:0]    input_val,
    input  logic [LEN_W-1:0]           input_length_bytes,
    input  logic [ROUND_W-1:0]         absorb_round_num,
    output word_t [RATE_WORDS-1:0]     state_output,
`ifdef EAGLESONG_ABSORB_LEN_CHECK_EN
    output logic                       len_err,
`endif
    output logic                       valid_out
);

    word_t [RATE_WORDS-1:0] w_words;
    word_t [RATE_WORDS-1:0] w_next;
    logic [LEN_W-1:0]       w_len_eff;
    logic                   w_load;

    word_t [RATE_WORDS-1:0] r_state;
    logic                   r_valid;

    // Oversized lengths saturate to a full block.
    assign w_len_eff = (input_length_bytes > MAX_LEN) ? MAX_LEN : input_length_bytes;

    eaglesong_absorb_pack u_pack (
        .i_input_val (input_val),
        .i_len       (w_len_eff),
        .i_round     (absorb_round_num),
        .o_words     (w_words)
    );

    always_comb begin
        w_next = '0;
        for (int unsigned j = 0; j < RATE_WORDS; j++) begin
            w_next[j] = ((absorb_round_num == '0) ? word_t'(0) : state_input[j]) ^ w_words[j];
        end
    end

`ifdef EAGLESONG_ABSORB_LEN_CHECK_EN
    logic w_len_bad;
    logic r_len_err;

    assign w_len_bad = (input_length_bytes == '0) || (input_length_bytes > MAX_LEN);
    assign w_load    = valid_in && !w_len_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= valid_in && w_len_bad;
        end
    end

    assign len_err = r_len_err;
`else
    assign w_load = valid_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_load;
            if (w_load) begin
                r_state <= w_next;
            end
        end
    end

    assign state_output = r_state;
    assign valid_out    = r_valid;

endmodule

// File: tb/tb_eaglesong_absorb.sv
// Directed self-checking bench for eaglesong_absorb; also covers EAGLESONG_ABSORB_LEN_CHECK_EN builds.
module tb_eaglesong_absorb;
    import eaglesong_pkg::*;

    logic                    clk;
    logic                    rst;
    logic                    valid_in;
    word_t [RATE_WORDS-1:0]  state_input;
    logic [255:0]            input_val;
    logic [6:0]              input_length_bytes;
    logic [7:0]              absorb_round_num;
    word_t [RATE_WORDS-1:0]  state_output;
    logic                    valid_out;
`ifdef EAGLESONG_ABSORB_LEN_CHECK_EN
    logic                    len_err;
`endif

    int n_checks;
    int n_errors;

    word_t [RATE_WORDS-1:0]  exp_w;
    word_t [RATE_WORDS-1:0]  t2_out;
    word_t [RATE_WORDS-1:0]  len1_out;

    localparam logic [255:0] MSG_HELLO = 256'h0A21646C726F77202C6F6C6C6548;
    localparam logic [255:0] MSG_32    =
        256'hF0076FEA59EB21788E3D74ACEB995CFDC2D1D6A5D36763D81583FDF3075FAB21;

    eaglesong_absorb dut (
        .clk                (clk),
        .rst                (rst),
        .valid_in           (valid_in),
        .state_input        (state_input),
        .input_val          (input_val),
        .input_length_bytes (input_length_bytes),
        .absorb_round_num   (absorb_round_num),
        .state_output       (state_output),
`ifdef EAGLESONG_ABSORB_LEN_CHECK_EN
        .len_err            (len_err),
`endif
        .valid_out          (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input string tag, input word_t [RATE_WORDS-1:0] got,
                             input word_t [RATE_WORDS-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: state_output got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [255:0] msg, input logic [6:0] len,
                         input logic [7:0] rnd);
        valid_in           = v;
        input_val          = msg;
        input_length_bytes = len;
        absorb_round_num   = rnd;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        state_input = '0;
        drive(1'b0, '0, 7'd1, 8'd0);

        #3;
        check_out("reset_state", state_output, '0);
        check_bit("reset_valid", valid_out, 1'b0);
`ifdef EAGLESONG_ABSORB_LEN_CHECK_EN
        check_bit("reset_len_err", len_err, 1'b0);
`endif
        #4 rst = 1'b0;
        @(negedge clk);

        // Hello world, round 0: state_input must be ignored
        for (int j = 0; j < RATE_WORDS; j++) state_input[j] = 32'h11111111;
        drive(1'b1, MSG_HELLO, 7'd14, 8'd0);
        cycle();
        exp_w = '0;
        exp_w[0] = 32'h48656C6C; exp_w[1] = 32'h6F2C2077;
        exp_w[2] = 32'h6F726C64; exp_w[3] = 32'h00210A06;
        check_out("hello_r0", state_output, exp_w);
        check_bit("hello_valid", valid_out, 1'b1);

        // Full 32-byte block, round 0
        drive(1'b1, MSG_32, 7'd32, 8'd0);
        cycle();
        t2_out[0] = 32'h21AB5F07; t2_out[1] = 32'hF3FD8315;
        t2_out[2] = 32'hD86367D3; t2_out[3] = 32'hA5D6D1C2;
        t2_out[4] = 32'hFD5C99EB; t2_out[5] = 32'hAC743D8E;
        t2_out[6] = 32'h7821EB59; t2_out[7] = 32'hEA6F07F0;
        check_out("full32_r0", state_output, t2_out);

        // Round 1 of a 32-byte message: only the delimiter lands in word 0
        state_input = t2_out;
        drive(1'b1, MSG_32, 7'd32, 8'd1);
        cycle();
        exp_w = t2_out;
        exp_w[0] = 32'h21AB5F01;
        check_out("full32_r1", state_output, exp_w);

        // Round 1 with a short message is pure pass-through
        for (int j = 0; j < RATE_WORDS; j++) state_input[j] = 32'h11111111 * j;
        drive(1'b1, MSG_HELLO, 7'd14, 8'd1);
        cycle();
        check_out("short_r1_pass", state_output, state_input);

        // Round 2 is pass-through even for a full-length message
        for (int j = 0; j < RATE_WORDS; j++) state_input[j] = 32'hA5A50000 + j;
        drive(1'b1, MSG_32, 7'd32, 8'd2);
        cycle();
        check_out("full32_r2_pass", state_output, state_input);

        // Single byte: partial word right-aligned
        drive(1'b1, 256'hAB, 7'd1, 8'd0);
        cycle();
        len1_out = '0;
        len1_out[0] = 32'h0000AB06;
        check_out("len1_r0", state_output, len1_out);
`ifdef EAGLESONG_ABSORB_LEN_CHECK_EN
        check_bit("len1_no_err", len_err, 1'b0);
`endif

        // Idle cycle holds the output and drops valid
        drive(1'b0, MSG_32, 7'd32, 8'd0);
        cycle();
        check_out("idle_hold", state_output, len1_out);
        check_bit("idle_valid", valid_out, 1'b0);

`ifdef EAGLESONG_ABSORB_LEN_CHECK_EN
        drive(1'b1, MSG_32, 7'd0, 8'd0);
        cycle();
        check_bit("len0_err", len_err, 1'b1);
        check_bit("len0_valid", valid_out, 1'b0);
        check_out("len0_hold", state_output, len1_out);

        drive(1'b1, MSG_32, 7'd33, 8'd0);
        cycle();
        check_bit("len33_err", len_err, 1'b1);
        check_bit("len33_valid", valid_out, 1'b0);
        check_out("len33_hold", state_output, len1_out);
`else
        // Length 0: delimiter at byte 0
        drive(1'b1, MSG_32, 7'd0, 8'd0);
        cycle();
        exp_w = '0;
        exp_w[0] = 32'h00000006;
        check_out("len0_delim", state_output, exp_w);
        check_bit("len0_valid", valid_out, 1'b1);

        // Length 33 saturates to 32
        drive(1'b1, MSG_32, 7'd33, 8'd0);
        cycle();
        check_out("len33_clamp", state_output, t2_out);
`endif

        // Load a known value, then async reset between clock edges
        drive(1'b1, MSG_HELLO, 7'd14, 8'd0);
        cycle();
        check_bit("pre_rst_valid", valid_out, 1'b1);
        valid_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_out("async_rst_state", state_output, '0);
        check_bit("async_rst_valid", valid_out, 1'b0);
        #2 rst = 1'b0;

        drive(1'b1, MSG_32, 7'd32, 8'd0);
        cycle();
        check_out("post_rst_full32", state_output, t2_out);
        check_bit("post_rst_valid", valid_out, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
